// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: memory-mapped 8-digit hex display controller.
// The CPU writes a 32-bit value in two 16-bit halves. A prescaler steps
// a 4-phase scan in which each phase lights digit p on seg and digit p+4
// on seg1. The scanned copy (disp) reloads only at frame boundaries, so a
// half-written value is never shown.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 100000, // clock cycles per scan phase (>=2)
  parameter bit LZ_BLANK = 1'b1    // 1 = suppress leading zero digits
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        io_write,
  input  logic        seg_cs,
  input  logic [1:0]  addr,
  input  logic [15:0] wdata,
  output logic [7:0]  seg,
  output logic [7:0]  seg1,
  output logic [7:0]  an
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [1:0] PHASE_LAST = 2'd3;

  logic [31:0]      value;   // CPU-visible register
  logic [31:0]      disp;    // frame-stable copy being scanned
  logic [CNT_W-1:0] cnt;     // prescaler
  logic [1:0]       phase;   // current scan phase 0..3
  logic             tick;    // last cycle of a scan phase
  logic             frame_load;
  logic             bus_write;

  // addr[0] selects nothing: both byte addresses of a half map to it.
  logic unused_addr0;
  assign unused_addr0 = addr[0];

  assign bus_write  = io_write && seg_cs;
  assign tick       = (cnt == CNT_MAX);
  assign frame_load = tick && (phase == PHASE_LAST);

  // Hex digit to segment pattern, bit0=a ... bit6=g, active-high.
  function automatic logic [6:0] enc(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0: code = 7'h3F;
      4'h1: code = 7'h06;
      4'h2: code = 7'h5B;
      4'h3: code = 7'h4F;
      4'h4: code = 7'h66;
      4'h5: code = 7'h6D;
      4'h6: code = 7'h7D;
      4'h7: code = 7'h07;
      4'h8: code = 7'h7F;
      4'h9: code = 7'h6F;
      4'hA: code = 7'h77;
      4'hB: code = 7'h7C;
      4'hC: code = 7'h39;
      4'hD: code = 7'h5E;
      4'hE: code = 7'h79;
      default: code = 7'h71;
    endcase
    return code;
  endfunction

  // CPU writes land in the selected half of value.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks run in.
  always_ff @(posedge clock) begin
    if (rst) begin
      value <= 32'd0;
    end else if (bus_write) begin
      if (addr[1]) value[31:16] <= wdata;
      else         value[15:0]  <= wdata;
    end
  end

  // Prescaler: one tick every SCAN_DIV cycles.
  always_ff @(posedge clock) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CNT_W'(1);
  end

  // Scan phase advances on each tick and wraps 3 -> 0.
  always_ff @(posedge clock) begin
    if (rst)       phase <= 2'd0;
    else if (tick) phase <= phase + 2'd1;
  end

  // Frame boundary: snapshot value into disp. A write on the same edge is
  // not seen here (value still holds its old contents) and shows a frame later.
  // NOTE: disp is explicitly reset so a reset mid-frame never lets stale
  // digits reappear before the next frame boundary.
  always_ff @(posedge clock) begin
    if (rst)             disp <= 32'd0;
    else if (frame_load) disp <= value;
  end

  // Leading-zero mask: digit k is blank when every nibble from k upward is 0.
  // Digit 0 always shows so a zero value reads as a single "0".
  logic [7:0] blank;
  always_comb begin
    // NOTE: every bit gets a value on every pass, so no latch is inferred.
    blank = 8'd0;
    for (int k = 1; k < 8; k++) begin
      blank[k] = LZ_BLANK && ((disp >> (4 * k)) == 32'd0);
    end
  end

  // Next-cycle outputs for the current phase: digit p on seg, digit p+4 on seg1.
  logic [3:0] nib_lo;
  logic [3:0] nib_hi;
  logic [7:0] an_nxt;
  logic [7:0] seg_nxt;
  logic [7:0] seg1_nxt;
  always_comb begin
    nib_lo = disp[{1'b0, phase, 2'b00} +: 4];
    nib_hi = disp[{1'b1, phase, 2'b00} +: 4];

    an_nxt = 8'd0;
    an_nxt[{1'b0, phase}] = 1'b1;
    an_nxt[{1'b1, phase}] = 1'b1;

    seg_nxt  = blank[{1'b0, phase}] ? 8'h00 : {1'b0, enc(nib_lo)};
    seg1_nxt = blank[{1'b1, phase}] ? 8'h00 : {1'b0, enc(nib_hi)};
  end

  // Registered drivers: glitch-free outputs, one cycle behind phase/disp.
  always_ff @(posedge clock) begin
    if (rst) begin
      an   <= 8'h00;
      seg  <= 8'h00;
      seg1 <= 8'h00;
    end else begin
      an   <= an_nxt;
      seg  <= seg_nxt;
      seg1 <= seg1_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Self-checking bench for seg7_scan_ctrl. Two instances share stimulus:
// one with leading-zero blanking, one without. A time-based reference model
// (cycle index since reset -> phase, frame boundaries) predicts all outputs.
module tb_seg7_scan_ctrl;

  localparam int D     = 4;      // SCAN_DIV used here
  localparam int FRAME = 4 * D;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        io_write = 1'b0;
  logic        seg_cs = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [15:0] wdata = 16'd0;
  logic [7:0]  seg_a, seg1_a, an_a;
  logic [7:0]  seg_b, seg1_b, an_b;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int          m_n = 0;          // clock edges since reset release
  logic [31:0] m_val = 32'd0;
  logic [31:0] m_disp = 32'd0;

  logic [7:0] seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  seg7_scan_ctrl #(.SCAN_DIV(D), .LZ_BLANK(1'b1)) dut (
    .clock(clock), .rst(rst), .io_write(io_write), .seg_cs(seg_cs),
    .addr(addr), .wdata(wdata), .seg(seg_a), .seg1(seg1_a), .an(an_a));

  seg7_scan_ctrl #(.SCAN_DIV(D), .LZ_BLANK(1'b0)) dut_nb (
    .clock(clock), .rst(rst), .io_write(io_write), .seg_cs(seg_cs),
    .addr(addr), .wdata(wdata), .seg(seg_b), .seg1(seg1_b), .an(an_b));

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Segment code shown for digit k of value v.
  function automatic logic [7:0] digit_code(input logic [31:0] v, input int k, input bit lz);
    logic [31:0] upper;
    upper = v >> (4 * k);
    if (lz && k > 0 && upper == 32'd0) return 8'h00;
    return seg_tab[upper[3:0]];
  endfunction

  // One clock: drive inputs, advance the model at the edge, check at negedge.
  task automatic cycle(input logic r, input logic wr, input logic cs,
                       input logic [1:0] a, input logic [15:0] d);
    int p;
    logic [7:0] e_an, e_sa, e_s1a, e_sb, e_s1b;
    rst = r; io_write = wr; seg_cs = cs; addr = a; wdata = d;
    @(posedge clock);
    if (r) begin
      m_n = 0; m_val = 32'd0; m_disp = 32'd0;
      e_an = 8'h00; e_sa = 8'h00; e_s1a = 8'h00; e_sb = 8'h00; e_s1b = 8'h00;
    end else begin
      p     = (m_n / D) % 4;
      e_an  = 8'(1 << p) | 8'(1 << (p + 4));
      e_sa  = digit_code(m_disp, p, 1'b1);
      e_s1a = digit_code(m_disp, p + 4, 1'b1);
      e_sb  = digit_code(m_disp, p, 1'b0);
      e_s1b = digit_code(m_disp, p + 4, 1'b0);
      if (m_n % FRAME == FRAME - 1) m_disp = m_val;
      if (wr && cs) begin
        if (a[1]) m_val[31:16] = d;
        else      m_val[15:0]  = d;
      end
      m_n++;
    end
    @(negedge clock);
    chk("scan_an", an_a, e_an);
    chk("scan_seg", seg_a, e_sa);
    chk("scan_seg1", seg1_a, e_s1a);
    chk("scan_an_nb", an_b, e_an);
    chk("scan_seg_nb", seg_b, e_sb);
    chk("scan_seg1_nb", seg1_b, e_s1b);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cycle(1'b0, 1'b0, 1'b0, 2'd0, 16'h0000);
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    cycle(1'b0, 1'b1, 1'b1, a, d);
  endtask

  // Advance until m_n mod FRAME equals m (at most one frame).
  task automatic run_to(input int m);
    for (int i = 0; i < FRAME && (m_n % FRAME) != m; i++) idle(1);
  endtask

  initial begin
    // 1. Reset, then idle scan of an all-zero display
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    cycle(1'b1, 1'b1, 1'b1, 2'd0, 16'h5555);   // write under reset is ignored
    chk("rst_an", an_a, 8'h00);
    chk("rst_seg", seg_a, 8'h00);
    chk("rst_seg1", seg1_a, 8'h00);
    idle(1);
    chk("first_an", an_a, 8'h11);
    chk("first_seg", seg_a, 8'h3F);
    chk("first_seg1", seg1_a, 8'h00);
    run_to(5);
    chk("idle_p1_an", an_a, 8'h22);
    chk("idle_p1_seg", seg_a, 8'h00);
    run_to(13);
    chk("idle_p3_an", an_a, 8'h88);
    idle(FRAME);

    // 2. 12345678 across both halves
    wr(2'd0, 16'h5678);
    wr(2'd2, 16'h1234);
    idle(2 * FRAME);
    run_to(1);
    chk("v1234_p0_an", an_a, 8'h11);
    chk("v1234_p0_seg", seg_a, 8'h7F);
    chk("v1234_p0_seg1", seg1_a, 8'h66);
    run_to(13);
    chk("v1234_p3_an", an_a, 8'h88);
    chk("v1234_p3_seg", seg_a, 8'h6D);
    chk("v1234_p3_seg1", seg1_a, 8'h06);

    // 3. 000000A0: blanking vs. no blanking (addr[0] set to show it is ignored)
    wr(2'd3, 16'h0000);
    wr(2'd1, 16'h00A0);
    idle(2 * FRAME);
    run_to(1);
    chk("a0_p0_seg", seg_a, 8'h3F);
    chk("a0_p0_seg1", seg1_a, 8'h00);
    chk("a0_p0_seg1_nb", seg1_b, 8'h3F);
    run_to(5);
    chk("a0_p1_seg", seg_a, 8'h77);
    run_to(9);
    chk("a0_p2_seg", seg_a, 8'h00);
    chk("a0_p2_seg_nb", seg_b, 8'h3F);

    // 4. Write exactly on the phase-3 tick: shows one frame late
    run_to(FRAME - 1);
    wr(2'd0, 16'hFFFF);
    run_to(1);
    chk("late_p0_seg", seg_a, 8'h3F);
    run_to(5);
    chk("late_p1_seg", seg_a, 8'h77);
    for (int p = 0; p < 4; p++) begin
      run_to(4 * p + 1);
      chk("ffff_seg", seg_a, 8'h71);
    end

    // 5. Incomplete bus strobes do not write
    cycle(1'b0, 1'b1, 1'b0, 2'd0, 16'h1111);
    cycle(1'b0, 1'b0, 1'b1, 2'd2, 16'h2222);
    idle(2 * FRAME);
    run_to(1);
    chk("nowr_p0_seg", seg_a, 8'h71);
    chk("nowr_p0_seg1", seg1_a, 8'h00);
    run_to(13);
    chk("nowr_p3_seg", seg_a, 8'h71);

    // 6. Reset mid-frame at phase 2 with DEADBEEF on display
    wr(2'd2, 16'hDEAD);
    wr(2'd0, 16'hBEEF);
    idle(2 * FRAME);
    run_to(9);
    chk("dead_p2_seg", seg_a, 8'h79);
    chk("dead_p2_seg1", seg1_a, 8'h79);
    cycle(1'b1, 1'b0, 1'b0, 2'd0, 16'h0000);
    chk("midrst_an", an_a, 8'h00);
    chk("midrst_seg", seg_a, 8'h00);
    chk("midrst_seg1", seg1_a, 8'h00);
    idle(1);
    chk("postrst_an", an_a, 8'h11);
    chk("postrst_seg", seg_a, 8'h3F);
    chk("postrst_seg1", seg1_a, 8'h00);
    idle(FRAME);

    // 7. Randomized traffic with occasional resets
    for (int i = 0; i < 800; i++) begin
      cycle(($urandom_range(0, 199) == 0),
            1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)),
            (($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
